// File: rtl/ps2_key_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_fifo
// Purpose  : PS/2 scan-code decoder (E0/F0 prefix stripping) feeding a
//            show-ahead key-event FIFO with edge-detected push and pop strobes.
//            Optional auto-repeat suppression: define PS2_TYPEMATIC_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        ps2_key_data,
    input  logic              ps2_key_pressed,
    input  logic              pop,
    input  logic              clear_ovf,
    output logic              key_valid,
    output logic [7:0]        key_code,
    output logic              key_ext,
    output logic              key_release,
    output logic [ADDR_W:0]   key_count,
    output logic              overflow
);

    localparam logic [1:0]      S_IDLE    = 2'd0;
    localparam logic [1:0]      S_EXT     = 2'd1;
    localparam logic [1:0]      S_BRK     = 2'd2;
    localparam logic [1:0]      S_EXT_BRK = 2'd3;
    localparam logic [7:0]      C_E0      = 8'hE0;
    localparam logic [7:0]      C_F0      = 8'hF0;
    localparam logic [ADDR_W:0] C_FULL    = DEPTH[ADDR_W:0];

    logic              pressed_q;
    logic              pop_q;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [9:0]        mem [DEPTH];

    logic w_byte_rx, w_pop_rx, w_is_prefix;
    logic w_evt_valid, w_evt_ext, w_evt_rel;
    logic w_filt_drop, w_push_req, w_full, w_empty, w_do_push, w_do_pop;

    assign w_byte_rx   = ps2_key_pressed & ~pressed_q;
    assign w_pop_rx    = pop & ~pop_q;
    assign w_is_prefix = (ps2_key_data == C_E0) || (ps2_key_data == C_F0);

    // Decoder FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pressed_q <= 1'b0;
            pop_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pressed_q <= ps2_key_pressed;
            pop_q     <= pop;
        end
    end

    // Decoder FSM: next state
    always_comb begin
        state_d = state_q;
        if (w_byte_rx) begin
            case (state_q)
                S_IDLE: begin
                    if (ps2_key_data == C_E0)      state_d = S_EXT;
                    else if (ps2_key_data == C_F0) state_d = S_BRK;
                end
                S_EXT: begin
                    if (ps2_key_data == C_F0)      state_d = S_EXT_BRK;
                    else if (!w_is_prefix)         state_d = S_IDLE;
                end
                S_BRK, S_EXT_BRK: begin
                    if (!w_is_prefix)              state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Decoder FSM: event outputs
    always_comb begin
        w_evt_valid = w_byte_rx & ~w_is_prefix;
        w_evt_ext   = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        w_evt_rel   = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_q;
    logic [8:0] held_key_q;
    logic       w_key_match;

    assign w_key_match = held_q && (held_key_q == {w_evt_ext, ps2_key_data});
    assign w_filt_drop = w_evt_valid & ~w_evt_rel & w_key_match;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_q     <= 1'b0;
            held_key_q <= 9'd0;
        end else if (w_evt_valid) begin
            if (!w_evt_rel && !w_key_match) begin
                held_q     <= 1'b1;
                held_key_q <= {w_evt_ext, ps2_key_data};
            end else if (w_evt_rel && w_key_match) begin
                held_q     <= 1'b0;
            end
        end
    end
`else
    assign w_filt_drop = 1'b0;
`endif

    assign w_push_req = w_evt_valid & ~w_filt_drop;
    assign w_full     = (count_q == C_FULL);
    assign w_empty    = (count_q == '0);
    assign w_do_pop   = w_pop_rx & ~w_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_do_push  = w_push_req & (~w_full | w_do_pop);

    always_comb begin
        count_d = count_q;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (clear_ovf)
            overflow_d = 1'b0;
        if (w_push_req && !w_do_push)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push)
            mem[wr_ptr_q] <= {w_evt_ext, w_evt_rel, ps2_key_data};
    end

    assign key_valid   = ~w_empty;
    assign key_ext     = mem[rd_ptr_q][9];
    assign key_release = mem[rd_ptr_q][8];
    assign key_code    = mem[rd_ptr_q][7:0];
    assign key_count   = count_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
- Sits between the PS/2 keyboard interface and the processor's keyboard input.
- Turns the raw scan-code byte stream into decoded key events: it strips the E0 and F0 prefixes and tags each event as extended and/or release.
- Buffers the events in a small show-ahead FIFO.
- The processor, clocked from a divided clock, consumes events with an edge-detected pop strobe, so a long pop pulse consumes exactly one event.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 3, pointer width; must equal log2(DEPTH).

Ports:
- clock  input  1  system clock (50 MHz domain).
- reset  input  1  asynchronous, active-high reset.
- ps2_key_data  input  8  scan-code byte from the PS/2 interface.
- ps2_key_pressed  input  1  byte-available strobe from the PS/2 interface.
- pop  input  1  consume request; acts on its rising edge only.
- clear_ovf  input  1  synchronous clear of the overflow flag.
- key_valid  output  1  FIFO non-empty.
- key_code  output  8  head entry scan code, E0/F0 prefixes stripped.
- key_ext  output  1  head entry was E0-prefixed.
- key_release  output  1  head entry was F0-prefixed (break code).
- key_count  output  ADDR_W+1  number of occupied entries.
- overflow  output  1  sticky flag: an event was lost because the FIFO was full.

Behaviour:
- Reset (async, active-high):
  - pointers and count = 0; decoder FSM = IDLE; edge registers = 0; overflow = 0.
  - key_valid = 0, key_count = 0.
  - key_code/key_ext/key_release are don't-care while key_valid = 0.
  - Reset mid-sequence (for example after F0 and before the code byte) discards the partial event.
- Byte strobe: byte_rx = ps2_key_pressed & ~ps2_key_pressed_q, where ps2_key_pressed_q is the registered previous value. One byte is accepted per rising edge, regardless of pulse length.
- Pop strobe: pop_rx = pop & ~pop_q, with pop_q registered the same way. A pop held high for many cycles consumes exactly one entry.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions on byte_rx:
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> push {ext=0, rel=0, byte}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT (redundant prefix ignored); other byte -> push {1,0,byte} -> IDLE.
  - BRK: E0 or F0 -> BRK (ignored); other byte -> push {0,1,byte} -> IDLE.
  - EXT_BRK: E0 or F0 -> EXT_BRK (ignored); other byte -> push {1,1,byte} -> IDLE.
  - Prefix bytes are never stored.
- Storage: 10-bit entries {ext, rel, code[7:0]}.
  - Show-ahead: the key_* outputs present mem[rd_ptr] while key_valid = 1.
  - Pointers wrap modulo DEPTH.
- Latency: push occurs on the clock edge that samples byte_rx. key_valid and key_count update on that same edge, so they are visible one cycle after the strobe rises.
- Pop on a non-empty FIFO advances rd_ptr on the sampling edge; the next entry is visible the following cycle.
- Boundary cases:
  - Pop on an empty FIFO: ignored; count is unchanged.
  - Push on a full FIFO with no pop: the event is dropped and overflow is set; the FSM still returns to IDLE.
  - Push and pop in the same cycle:
    - FIFO full: both occur, count stays at DEPTH, overflow not set.
    - FIFO empty: push only.
    - Otherwise: both occur, count unchanged.
  - overflow stays set until clear_ovf = 1 or reset. If clear_ovf coincides with a new overflow event, set wins.
- key_count ranges 0..DEPTH inclusive.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - The block keeps a register held_key = {ext, code} and a held flag.
  - A make event equal to held_key while held = 1 is discarded, which suppresses auto-repeat. It does not set overflow.
  - Any accepted make event loads held_key and sets held.
  - A release event whose {ext, code} matches held_key clears held.
  - Release events are always pushed.
  - Reset clears held.
- Undefined: every make event is pushed, including typematic repeats; held_key logic is absent.

Test Plan:
- Bytes 1C, F0, 1C (one strobe each, 3 cycles apart) -> two entries: {0,0,1C} then {0,1,1C}; key_count = 2; key_valid rises one cycle after the first strobe.
- Bytes E0, 75, E0, F0, 75 -> entries {1,0,75} and {1,1,75}; no prefix byte is stored.
- Nine make codes 15..1D into a DEPTH=8 FIFO -> count = 8, overflow = 1, head = 15. Then clear_ovf -> overflow = 0. Pop held high for 20 cycles -> exactly one pop, head = 16.
- FIFO full (count 8) with byte_rx and pop_rx in the same cycle -> count stays 8, overflow stays 0, the new entry lands at the tail.
- Reset asserted asynchronously after byte F0, then byte 1C after release -> single entry {0,0,1C}, not a release.
- With PS2_TYPEMATIC_FILTER_EN, bytes 1C, 1C, 1C, F0, 1C, 1C -> entries {0,0,1C}, {0,1,1C}, {0,0,1C}. Without the macro -> 5 entries.
